hood_mode_fsm: RTL

Central mode register of the kitchen exhaust hood. Consumes the one-cycle mode request pulses from the per-mode controllers and the 1 Hz tick, and holds `current_mode`, which feeds back to those controllers and to the display and fan drivers. Enforces the timed modes: hurricane (third), hurricane exit countdown, and self-clean. Also enforces the once-per-power-cycle hurricane limit.

---
 rtl/hood_mode_fsm.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/hood_mode_fsm.sv
// Central operating-mode register of the exhaust hood: arbitrates mode request
// pulses, runs the timed-mode countdowns and tracks the once-per-power-cycle hurricane limit.
module hood_mode_fsm #(
    parameter int MODE_WIDTH = 3,
    parameter int CNT_WIDTH  = 8,
    parameter int THIRD_SECS = 60,
    parameter int EXIT_SECS  = 60,
    parameter int CLEAN_SECS = 180
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  power_on,
    input  logic                  tick_1s,
    input  logic                  first_mode_toggle,
    input  logic                  second_mode_toggle,
    input  logic                  third_mode_toggle,
    input  logic                  clean_toggle,
    input  logic                  standby_toggle,
    output logic [MODE_WIDTH-1:0] current_mode,
    output logic [CNT_WIDTH-1:0]  countdown,
    output logic                  third_used,
    output logic                  mode_changed
);

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        STAND   = 3'd1,
        FIRST   = 3'd2,
        SECOND  = 3'd3,
        THIRD   = 3'd4,
        CLEAN   = 3'd5,
        EXITING = 3'd6
    } mode_e;

    localparam logic [CNT_WIDTH-1:0] THIRD_LOAD = CNT_WIDTH'(THIRD_SECS);
    localparam logic [CNT_WIDTH-1:0] EXIT_LOAD  = CNT_WIDTH'(EXIT_SECS);
    localparam logic [CNT_WIDTH-1:0] CLEAN_LOAD = CNT_WIDTH'(CLEAN_SECS);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    mode_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  third_used_q, third_used_d;
    logic                  mode_changed_q, mode_changed_d;
    logic                  timed;
    logic                  expire;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        third_used_d   = third_used_q;
        mode_changed_d = 1'b0;

        timed  = (state_q == THIRD) || (state_q == EXITING) || (state_q == CLEAN);
        expire = timed && tick_1s && (cnt_q == CNT_ONE);

        // Plain decrement first; any load or state exit below overrides it.
        if (timed && tick_1s && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        if (!power_on) begin
            state_d = OFF;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                OFF: begin
                    state_d      = STAND;
                    cnt_d        = CNT_ZERO;
                    third_used_d = 1'b0;
                end
                STAND: begin
                    if (first_mode_toggle) begin
                        state_d = FIRST;
                        cnt_d   = CNT_ZERO;
                    end else if (second_mode_toggle) begin
                        state_d = SECOND;
                        cnt_d   = CNT_ZERO;
                    end else if (third_mode_toggle && !third_used_q) begin
                        state_d      = THIRD;
                        cnt_d        = THIRD_LOAD;
                        third_used_d = 1'b1;
                    end else if (clean_toggle) begin
                        state_d = CLEAN;
                        cnt_d   = CLEAN_LOAD;
                    end
                end
                FIRST: begin
                    if (standby_toggle) begin
                        state_d = STAND;
                        cnt_d   = CNT_ZERO;
                    end else if (second_mode_toggle) begin
                        state_d = SECOND;
                        cnt_d   = CNT_ZERO;
                    end
                end
                SECOND: begin
                    if (standby_toggle) begin
                        state_d = STAND;
                        cnt_d   = CNT_ZERO;
                    end else if (first_mode_toggle) begin
                        state_d = FIRST;
                        cnt_d   = CNT_ZERO;
                    end
                end
                THIRD: begin
                    // A standby request beats a coincident expiry tick.
                    if (standby_toggle) begin
                        state_d = EXITING;
                        cnt_d   = EXIT_LOAD;
                    end else if (expire) begin
                        state_d = SECOND;
                        cnt_d   = CNT_ZERO;
                    end
                end
                EXITING, CLEAN: begin
                    if (expire) begin
                        state_d = STAND;
                        cnt_d   = CNT_ZERO;
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        mode_changed_d = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= OFF;
            cnt_q          <= CNT_ZERO;
            third_used_q   <= 1'b0;
            mode_changed_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            third_used_q   <= third_used_d;
            mode_changed_q <= mode_changed_d;
        end
    end

    assign current_mode = MODE_WIDTH'(state_q);
    assign countdown    = cnt_q;
    assign third_used   = third_used_q;
    assign mode_changed = mode_changed_q;

endmodule
